// File: rtl/mem_arbiter_pkg.sv
// Shared bus widths, FSM encodings and request payload type for the RAM-port arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WSEL_W = 4;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
        logic [WSEL_W-1:0] wsel;
    } mem_req_t;

endpackage

// File: rtl/mem_watchdog.sv
// Saturating transaction-length counter; flags the last allowed cycle of a transaction.
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 32'd256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable && (count_q < CW'(TIMEOUT)))
            count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // TIMEOUT == 0 disables the watchdog entirely
    assign expired = (TIMEOUT != 0) && enable && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single RAM port: one transaction at a time,
// round-robin or fixed priority, with a watchdog that errors out stuck transactions.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT     = 32'd256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [WSEL_W-1:0] m0_wsel,
    input  logic              m0_valid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    output logic              m0_error,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [WSEL_W-1:0] m1_wsel,
    input  logic              m1_valid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              m1_error,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_wdata,
    output logic [WSEL_W-1:0] s_wsel,
    output logic              s_valid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    input  logic              s_error
);

    logic [0:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic       busy, start, sel_valid, wd_expired;
    logic       resp_ok, ready_fwd, error_fwd;
    mem_req_t   m0_req, m1_req, sel_req;

    assign m0_req    = '{address: m0_address, wdata: m0_wdata, wsel: m0_wsel};
    assign m1_req    = '{address: m1_address, wdata: m1_wdata, wsel: m1_wsel};
    assign busy      = (state_q == ARB_BUSY);
    assign sel_valid = grant_q ? m1_valid : m0_valid;
    assign sel_req   = grant_q ? m1_req : m0_req;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .enable  (busy),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        start   = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (m0_valid || m1_valid) begin
                start   = 1'b1;
                state_d = ARB_BUSY;
                if (m0_valid && m1_valid)
                    grant_d = ROUND_ROBIN ? !last_q : 1'b0;
                else
                    grant_d = m1_valid;
            end
        end else begin
            // a master abandoning its request also ends the transaction
            if (!sel_valid || s_ready || s_error || wd_expired) begin
                state_d = ARB_IDLE;
                last_d  = grant_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // responses reach a master only while it still holds its request, and never under reset
    assign resp_ok   = busy && sel_valid && !rst;
    assign ready_fwd = resp_ok && s_ready;
    assign error_fwd = resp_ok && (s_error || (wd_expired && !s_ready));

    always_comb begin
        s_valid   = busy && sel_valid;
        s_address = busy ? sel_req.address : '0;
        s_wdata   = busy ? sel_req.wdata   : '0;
        s_wsel    = busy ? sel_req.wsel    : '0;
        m0_ready  = ready_fwd && !grant_q;
        m0_error  = error_fwd && !grant_q;
        m1_ready  = ready_fwd &&  grant_q;
        m1_error  = error_fwd &&  grant_q;
    end

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

endmodule
